// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the multi-cycle serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } adder_state_t;

  // Bits needed to count n values; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder cell.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum_c,
  output logic o_cout_c
);

  assign o_sum_c  = i_a ^ i_b ^ i_cin;
  assign o_cout_c = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder_slice.sv
// W-bit ripple-carry slice built from full_adder cells; also exposes the carry
// into its top bit so the caller can derive signed overflow.
module serial_adder_slice #(
  parameter int unsigned W = 1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum_c,
  output logic         o_cout_c,
  output logic         o_cmsb_c
);

  logic [W:0] w_carry;

  assign w_carry[0] = i_cin;

  // Ripple chain: carry out of cell g feeds cell g+1.
  for (genvar g = 0; g < W; g++) begin : g_fa
    full_adder u_fa (
      .i_a      (i_a[g]),
      .i_b      (i_b[g]),
      .i_cin    (w_carry[g]),
      .o_sum_c  (o_sum_c[g]),
      .o_cout_c (w_carry[g+1])
    );
  end

  assign o_cout_c = w_carry[W];
  assign o_cmsb_c = w_carry[W-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle N-bit adder/subtractor processing CHUNK bits per clock with
// valid/ready handshakes on both the operand and the result side.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned CHUNK = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int unsigned NCHUNK = N / CHUNK;
  localparam int unsigned KW     = cnt_width(NCHUNK);
  localparam int unsigned IW     = cnt_width(N);
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  // Reject parameter sets the chunked datapath cannot cover exactly.
  if ((N < 2) || ((N % CHUNK) != 0)) begin : g_param_err
    $error("serial_adder: N must be >= 2 and divisible by CHUNK");
  end

  adder_state_t r_state;
  adder_state_t w_state_next;

  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic [N-1:0]     r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [IW-1:0]    w_base;
  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_b_sl;
  logic [CHUNK-1:0] w_sum_sl;
  logic             w_co;
  logic             w_cmsb;

  // Select the operand slice for the current chunk index.
  assign w_base = IW'(r_k * CHUNK);
  assign w_a_sl = r_a[w_base +: CHUNK];
  assign w_b_sl = r_b[w_base +: CHUNK];

  serial_adder_slice #(.W(CHUNK)) u_slice (
    .i_a      (w_a_sl),
    .i_b      (w_b_sl),
    .i_cin    (r_carry),
    .o_sum_c  (w_sum_sl),
    .o_cout_c (w_co),
    .o_cmsb_c (w_cmsb)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid)       w_state_next = S_RUN;
      S_RUN:  if (r_k == K_LAST)  w_state_next = S_DONE;
      S_DONE: if (out_ready)      w_state_next = S_IDLE;
      default:                    w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, per-chunk accumulation and final flag capture.
  // Subtraction is folded in at accept time: b is inverted and the
  // borrow-in becomes an inverted carry-in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_k     <= '0;
          end
        end
        S_RUN: begin
          r_sum[w_base +: CHUNK] <= w_sum_sl;
          r_carry                <= w_co;
          if (r_k == K_LAST) begin
            r_cout <= w_co;
            r_ovf  <= w_cmsb ^ w_co;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake flags decode from the state register only.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder across several N/CHUNK configurations.
module tb_serial_adder;

  logic        clk;
  logic        rst_n;
  logic [15:0] ta;
  logic [15:0] tbb;
  logic        tcin;
  logic        tsub;
  logic        tout_ready;
  logic [5:0]  in_valid_v;
  logic [5:0]  in_ready_v;
  logic [5:0]  out_valid_v;
  logic [5:0]  cout_v;
  logic [5:0]  ovf_v;
  logic [7:0]  sum0, sum1, sum2;
  logic [15:0] sum3, sum4, sum5;

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // idx 0: N8/C1, 1: N8/C2, 2: N8/C4, 3: N16/C1, 4: N16/C4, 5: N16/C16
  serial_adder #(.N(8), .CHUNK(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(ta[7:0]), .b(tbb[7:0]), .cin(tcin), .sub(tsub), .out_valid(out_valid_v[0]),
    .out_ready(tout_ready), .sum(sum0), .cout(cout_v[0]), .overflow(ovf_v[0]));
  serial_adder #(.N(8), .CHUNK(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(ta[7:0]), .b(tbb[7:0]), .cin(tcin), .sub(tsub), .out_valid(out_valid_v[1]),
    .out_ready(tout_ready), .sum(sum1), .cout(cout_v[1]), .overflow(ovf_v[1]));
  serial_adder #(.N(8), .CHUNK(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(ta[7:0]), .b(tbb[7:0]), .cin(tcin), .sub(tsub), .out_valid(out_valid_v[2]),
    .out_ready(tout_ready), .sum(sum2), .cout(cout_v[2]), .overflow(ovf_v[2]));
  serial_adder #(.N(16), .CHUNK(1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .a(ta), .b(tbb), .cin(tcin), .sub(tsub), .out_valid(out_valid_v[3]),
    .out_ready(tout_ready), .sum(sum3), .cout(cout_v[3]), .overflow(ovf_v[3]));
  serial_adder #(.N(16), .CHUNK(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[4]), .in_ready(in_ready_v[4]),
    .a(ta), .b(tbb), .cin(tcin), .sub(tsub), .out_valid(out_valid_v[4]),
    .out_ready(tout_ready), .sum(sum4), .cout(cout_v[4]), .overflow(ovf_v[4]));
  serial_adder #(.N(16), .CHUNK(16)) u_d5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[5]), .in_ready(in_ready_v[5]),
    .a(ta), .b(tbb), .cin(tcin), .sub(tsub), .out_valid(out_valid_v[5]),
    .out_ready(tout_ready), .sum(sum5), .cout(cout_v[5]), .overflow(ovf_v[5]));

  function automatic int nbits(input int idx);
    return (idx < 3) ? 8 : 16;
  endfunction

  function automatic int chunk_of(input int idx);
    case (idx)
      0: return 1;
      1: return 2;
      2: return 4;
      3: return 1;
      4: return 4;
      default: return 16;
    endcase
  endfunction

  function automatic logic [15:0] get_sum(input int idx);
    case (idx)
      0: return 16'(sum0);
      1: return 16'(sum1);
      2: return 16'(sum2);
      3: return sum3;
      4: return sum4;
      default: return sum5;
    endcase
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input int n, input logic [15:0] a, input logic [15:0] b,
                                input logic cin, input logic sub,
                                output logic [15:0] s, output logic c, output logic o);
    longint m, ua, ub, sa, sb, ci, ur, sr;
    m  = longint'(1) << n;
    ua = longint'(a) % m;
    ub = longint'(b) % m;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    ci = cin ? longint'(1) : longint'(0);
    if (!sub) begin
      ur = ua + ub + ci;
      sr = sa + sb + ci;
      c  = (ur >= m);
    end else begin
      ur = ua - ub - ci;
      sr = sa - sb - ci;
      c  = (ur >= 0);
    end
    s = 16'(((ur % m) + m) % m);
    o = (sr < -(m / 2)) || (sr >= (m / 2));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction on DUT idx. hold<0: out_ready high before DONE;
  // hold>=0: DONE held for that many extra cycles before out_ready rises.
  task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input int hold, input bit toggle);
    int n, nc, lat;
    logic [15:0] es;
    logic ec, eo;
    n  = nbits(idx);
    nc = n / chunk_of(idx);
    model(n, a, b, cin, sub, es, ec, eo);
    chk("in_ready_idle", 32'(in_ready_v[idx]), 32'd1);
    ta = a; tbb = b; tcin = cin; tsub = sub;
    tout_ready = (hold < 0);
    in_valid_v[idx] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[idx] = 1'b0;
    lat = 0;
    while (!out_valid_v[idx] && lat < 200) begin
      if (toggle) begin
        ta = 16'($urandom); tbb = 16'($urandom);
        tcin = 1'($urandom); tsub = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("edges_to_valid", 32'(lat), 32'(nc));
    chk("sum", 32'(get_sum(idx)), 32'(es));
    chk("cout", 32'(cout_v[idx]), 32'(ec));
    chk("overflow", 32'(ovf_v[idx]), 32'(eo));
    chk("in_ready_busy", 32'(in_ready_v[idx]), 32'd0);
    if (hold > 0) begin
      repeat (hold) begin
        if (toggle) begin ta = 16'($urandom); tbb = 16'($urandom); end
        @(posedge clk); #1;
      end
      chk("held_valid", 32'(out_valid_v[idx]), 32'd1);
      chk("held_sum", 32'(get_sum(idx)), 32'(es));
      chk("held_cout", 32'(cout_v[idx]), 32'(ec));
      chk("held_ovf", 32'(ovf_v[idx]), 32'(eo));
      chk("held_in_ready", 32'(in_ready_v[idx]), 32'd0);
    end
    tout_ready = 1'b1;
    @(posedge clk); #1;
    tout_ready = 1'b0;
    chk("valid_after_handoff", 32'(out_valid_v[idx]), 32'd0);
    chk("ready_after_handoff", 32'(in_ready_v[idx]), 32'd1);
  endtask

  initial begin
    int idx;
    checks = 0; failures = 0;
    rst_n = 1'b0;
    ta = '0; tbb = '0; tcin = 1'b0; tsub = 1'b0;
    tout_ready = 1'b0; in_valid_v = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready_v), 32'h3F);
    chk("rst_out_valid", 32'(out_valid_v), 32'h0);
    chk("rst_cout", 32'(cout_v), 32'h0);
    chk("rst_ovf", 32'(ovf_v), 32'h0);
    chk("rst_sum3", 32'(sum3), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cases.
    do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    do_op(2, 16'h007F, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    do_op(1, 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
    do_op(1, 16'h0080, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
    do_op(1, 16'h0010, 16'h0000, 1'b1, 1'b1, 0, 1'b0);
    // Backpressure with inputs toggling during RUN and DONE.
    do_op(1, 16'h005A, 16'h0033, 1'b1, 1'b1, 5, 1'b1);
    // out_ready already high when DONE is entered.
    do_op(3, 16'h8000, 16'h8000, 1'b0, 1'b0, -1, 1'b0);

    // Reset mid-RUN at k=3 on the N=8, CHUNK=1 instance.
    ta = 16'h00FF; tbb = 16'h0000; tcin = 1'b0; tsub = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid_v[0]), 32'd0);
    chk("midrst_sum", 32'(sum0), 32'd0);
    chk("midrst_cout", 32'(cout_v[0]), 32'd0);
    chk("midrst_ovf", 32'(ovf_v[0]), 32'd0);
    chk("midrst_ready", 32'(in_ready_v[0]), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(0, 16'h0003, 16'h0004, 1'b0, 1'b0, 0, 1'b0);

    // Randomised sweep on the 16-bit instances.
    for (int i = 0; i < 1000; i++) begin
      idx = 3 + int'($urandom_range(0, 2));
      do_op(idx, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 4)) - 1, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle N-bit adder/subtractor that reuses the `full_adder` cell to process CHUNK bits per clock. Operands are latched through a valid/ready handshake and the result is returned through a second valid/ready handshake. It is the sequential successor to the combinational one-bit `full_adder`. It serves as the area-lean arithmetic unit for the game-of-life datapath, for example neighbour-count accumulation.

## Interface
- `N`, default 8: operand and result width; N ≥ 2.
- `CHUNK`, default 1: bits processed per RUN cycle; must divide N; 1 ≤ CHUNK ≤ N.
- `clk` input, 1: clock; all state updates on the rising edge.
- `rst_n` input, 1: reset, asynchronous, active-low.
- `in_valid` input, 1: operand bundle valid.
- `in_ready` output, 1: block can accept operands.
- `a` input, N: operand A, two's complement or unsigned.
- `b` input, N: operand B.
- `cin` input, 1: carry-in in add mode; borrow-in in subtract mode.
- `sub` input, 1: 0 computes a+b+cin; 1 computes a−b−cin.
- `out_valid` output, 1: result valid.
- `out_ready` input, 1: consumer accepts result.
- `sum` output, N: result.
- `cout` output, 1: final carry. In subtract mode, 1 means no borrow.
- `overflow` output, 1: signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch `a`, `sub ? ~b : b`, the initial carry `cin ^ sub`, and `sub`. Clear chunk counter `k`. Go to RUN.
- RUN:
  - Each cycle, feed latched slice [k·CHUNK +: CHUNK] through a CHUNK-wide ripple of `full_adder` instances.
  - Write the slice result into the `sum` register. Register the carry-out for the next cycle.
  - When k = N/CHUNK−1, capture `cout` and `overflow` and go to DONE. Otherwise increment k.
- DONE:
  - `out_valid`=1. `sum`, `cout` and `overflow` are held stable.
  - On `out_ready`, go to IDLE.
- Overflow = carry into bit N−1 XOR carry out of bit N−1, taken from the final chunk.
- Arithmetic is modulo 2^N. No sign extension; the result width equals N.
- Inputs `a`, `b`, `cin` and `sub` are ignored outside the IDLE accept cycle. Changes to them during RUN or DONE do not affect the result.
- `in_ready` and `out_valid` decode combinationally from the state register only. They never depend combinationally on `in_valid` or `out_ready`.
- Reset, asynchronous at any time including mid-RUN or during DONE:
  - state=IDLE, k=0, `sum`=0, `cout`=0, `overflow`=0, `out_valid`=0, `in_ready`=1.
  - Any operation in flight is discarded.

## Timing
- Accept at edge t.
- RUN occupies edges t+1 … t+N/CHUNK.
- `out_valid` is high starting the cycle after edge t+N/CHUNK. Latency is N/CHUNK+1 cycles from accept to `out_valid`.
- Result handshake completes at the first edge with `out_valid && out_ready`. `in_ready` rises the following cycle.
- No overlap: a new accept cannot occur in the same cycle as result handoff. Minimum period is N/CHUNK+2 cycles per operation.
- If `out_ready` is held low, DONE persists indefinitely. Outputs stay constant and `in_ready` stays 0.
- If `out_ready` is already high when DONE is entered, the handoff occurs after exactly one DONE cycle.
- During IDLE and RUN, `sum` holds the partial or previous value. It is meaningful only while `out_valid`=1.

## Structure
- Shared package `serial_adder_pkg`: state enum `adder_state_t` {S_IDLE, S_RUN, S_DONE}.
- Elaboration check: N % CHUNK == 0. Fail with `$error` otherwise.
- Sub-module: existing `full_adder`, instantiated CHUNK times in a generate loop to form the per-cycle ripple slice.
- Counter width is $clog2(N/CHUNK), minimum 1 bit.

## Test plan
- Add carry-out, N=8, CHUNK=1: a=8'hFF, b=8'h01, cin=0, sub=0 → after 9 cycles, `out_valid`=1, `sum`=8'h00, `cout`=1, `overflow`=0.
- Signed overflow, N=8, CHUNK=4: a=8'h7F, b=8'h01, add → `out_valid` 3 cycles after accept, `sum`=8'h80, `cout`=0, `overflow`=1.
- Subtract with borrow and overflow, N=8, CHUNK=2:
  - 8'h05−8'h07, cin=0 → `sum`=8'hFE, `cout`=0, `overflow`=0.
  - 8'h80−8'h01 → `sum`=8'h7F, `cout`=1, `overflow`=1.
  - 8'h10−8'h00 with cin=1 → `sum`=8'h0F.
- Backpressure and input isolation:
  - Hold `out_ready`=0 for 5 cycles in DONE → `sum` and flags stable, `in_ready`=0.
  - Toggle `a` and `b` during RUN → result unchanged.
  - Raise `out_ready` → `in_ready`=1 next cycle.
- Reset mid-RUN: assert `rst_n`=0 at k=3 of an N=8, CHUNK=1 op → immediately `out_valid`=0, `sum`=0, `cout`=0, `overflow`=0, `in_ready`=1. A following op 8'h03+8'h04 yields 8'h07.
- Randomised sweep (1000 ops, N=16, CHUNK ∈ {1,4,16}) against a behavioural model: random `sub`, `cin`, `out_ready` throttling → all results, `cout` and `overflow` match.
